cpu_register_file_write_arbiter: RTL
====================================

// Module: cpu_register_file_write_arbiter
// PURPOSE
//  Shares the single write port of the CPU register file among NUMBER_OF_REQUESTERS writers (ALU, load unit, ...).
//  Round-robin arbitration with valid/ready handshake; one registered write per cycle to the register file.
//  Also sequences a bulk clear (zero regs 1..NUMBER_OF_REGISTERS-1, one per cycle) that pre-empts all requesters.
// PARAMETERS
//  NUMBER_OF_REGISTERS   32  register count; address width A = $clog2(NUMBER_OF_REGISTERS)
//  NUMBER_OF_REQUESTERS  4   writer count N (>=2)
//  DATA_WIDTH            8   signed write data width; matches register file bus (BUS_WIDTH+1)
// PORTS
//  clock_in                    in   1      single clock; all state on posedge
//  reset_in                    in   1      asynchronous, active-low reset
//  request_valid_in            in   N      per-requester write request
//  request_address_in          in   N*A    flattened; requester i at [i*A +: A]
//  request_data_in             in   N*DATA_WIDTH  flattened signed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  request_ready_out           out  N      one-hot grant; transfer when valid & ready same cycle
//  clear_start_in              in   1      pulse: start bulk clear
//  busy_out                    out  1      clear in progress (incl. last clear write on output)
//  write_enable_out            out  1      to register file write_enable_in
//  write_register_address_out  out  A      to register file write_register_address_in
//  write_data_out              out  DATA_WIDTH  to register file write_data_in
//  grant_index_out             out  $clog2(N)  index of requester whose write is on the output (debug)
// BEHAVIOUR
//  Reset (reset_in=0, async): state=ARBITRATE, rr_pointer=0, clear counter=1; all outputs 0.
//  FSM states: ARBITRATE, CLEAR.
//   ARBITRATE -> CLEAR when clear_start_in=1 (sampled posedge). CLEAR -> ARBITRATE after issuing addr NUMBER_OF_REGISTERS-1.
//   clear_start_in ignored while in CLEAR.
//  ARBITRATE grant (combinational from registered state + request_valid_in):
//   - search i = rr_pointer, rr_pointer+1, ... mod N; first valid requester gets request_ready_out[i]=1; at most one bit set.
//   - no valid -> request_ready_out=0, rr_pointer unchanged.
//   - on grant of i: rr_pointer <= (i+1) mod N.
//   - clear_start_in=1 same cycle: request_ready_out=0 (clear wins; no transfer, pointer unchanged).
//  CLEAR: request_ready_out=0 every cycle; requesters hold valid/address/data stable until granted.
//  Output stage (registered, latency 1): transfer at edge T -> write_enable_out/address/data/grant_index valid in cycle T+1.
//   - no transfer and not clearing -> write_enable_out=0; address/data/grant_index hold previous values.
//   - granted write to address 0: handshake completes, write_enable_out stays 0 (dropped; reg 0 is hard zero).
//  Clear sequence: clear_start sampled at edge T -> CLEAR from T+1; write_enable_out=1, data=0, address 1,2,...,N_REG-1
//   in cycles T+2 .. T+NUMBER_OF_REGISTERS (one per cycle, no gaps); grant_index_out=0 during clear writes.
//   busy_out=1 from cycle T+1 through T+NUMBER_OF_REGISTERS inclusive; first requester grant possible cycle T+NUMBER_OF_REGISTERS.
//  Data passes unchanged (no arithmetic); address counter is A bits, never wraps past NUMBER_OF_REGISTERS-1.
//  Reset asserted mid-clear or mid-transfer: abort immediately; in-flight write discarded (write_enable_out=0 async).
// TESTING
//  1 Single requester 2 valid, addr 5, data -3 -> ready[2]=1 that cycle; next cycle we=1, addr=5, data=8'hFD, grant_index=2.
//  2 All 4 valid continuously from reset -> grants 0,1,2,3,0,... one per cycle; we=1 every cycle after first.
//  3 Requesters 1,3 valid, pointer=2 -> grant 3, then 1; idle cycle between leaves pointer unchanged.
//  4 clear_start with requester 0 valid same cycle -> no ready; we=1 addr 1..31 data 0 on 31 consecutive cycles; busy 32 cycles; then grant 0.
//  5 Requester 1 writes addr 0 data 7 -> ready[1]=1, next cycle we=0; pointer advances to 2.
//  6 Reset pulled low at clear address 10 -> outputs 0 immediately; after release state ARBITRATE, busy=0, pointer=0.

Source files
------------

// File: rtl/cpu_register_file_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a pre-empting bulk clear
// that zeroes registers 1..NUMBER_OF_REGISTERS-1 at one register per cycle.
module cpu_register_file_write_arbiter #(
  parameter int unsigned NUMBER_OF_REGISTERS  = 32,
  parameter int unsigned NUMBER_OF_REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH           = 8,
  localparam int unsigned AddrWidth = $clog2(NUMBER_OF_REGISTERS),
  localparam int unsigned IdxWidth  = $clog2(NUMBER_OF_REQUESTERS)
) (
  input  logic                                       clock_in,
  input  logic                                       reset_in,
  input  logic [NUMBER_OF_REQUESTERS-1:0]            request_valid_in,
  input  logic [NUMBER_OF_REQUESTERS*AddrWidth-1:0]  request_address_in,
  input  logic [NUMBER_OF_REQUESTERS*DATA_WIDTH-1:0] request_data_in,
  output logic [NUMBER_OF_REQUESTERS-1:0]            request_ready_out,
  input  logic                                       clear_start_in,
  output logic                                       busy_out,
  output logic                                       write_enable_out,
  output logic [AddrWidth-1:0]                       write_register_address_out,
  output logic [DATA_WIDTH-1:0]                      write_data_out,
  output logic [IdxWidth-1:0]                        grant_index_out
);

  typedef enum logic {StArbitrate, StClear} state_e;

  localparam logic [AddrWidth-1:0] LastReg = AddrWidth'(NUMBER_OF_REGISTERS - 1);
  localparam logic [IdxWidth-1:0]  LastReq = IdxWidth'(NUMBER_OF_REQUESTERS - 1);

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   rr_q, rr_d;
  logic [AddrWidth-1:0]  clr_cnt_q, clr_cnt_d;
  logic                  we_q, we_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IdxWidth-1:0]   gidx_q, gidx_d;
  logic                  clr_wr_q, clr_wr_d;

  logic                  grant_found;
  logic [IdxWidth-1:0]   grant_idx;
  logic [IdxWidth-1:0]   cand;
  logic [AddrWidth-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (state_q == StArbitrate && !clear_start_in) begin
      for (int unsigned k = 0; k < NUMBER_OF_REQUESTERS; k++) begin
        cand = IdxWidth'((32'(rr_q) + k) % NUMBER_OF_REQUESTERS);
        if (!grant_found && request_valid_in[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    request_ready_out = '0;
    if (grant_found) request_ready_out[grant_idx] = 1'b1;
  end

  assign sel_addr = request_address_in[32'(grant_idx) * AddrWidth +: AddrWidth];
  assign sel_data = request_data_in[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    clr_cnt_d = clr_cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    gidx_d    = gidx_q;
    clr_wr_d  = 1'b0;
    case (state_q)
      StArbitrate: begin
        if (clear_start_in) begin
          state_d = StClear;
        end else if (grant_found) begin
          rr_d = (grant_idx == LastReq) ? '0 : grant_idx + 1'b1;
          // Register 0 is hard-wired to zero: accept the handshake, drop the write.
          if (sel_addr != '0) begin
            we_d   = 1'b1;
            addr_d = sel_addr;
            data_d = sel_data;
            gidx_d = grant_idx;
          end
        end
      end
      StClear: begin
        we_d     = 1'b1;
        addr_d   = clr_cnt_q;
        data_d   = '0;
        gidx_d   = '0;
        clr_wr_d = 1'b1;
        if (clr_cnt_q == LastReg) begin
          state_d   = StArbitrate;
          clr_cnt_d = AddrWidth'(1);
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = StArbitrate;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= StArbitrate;
      rr_q      <= '0;
      clr_cnt_q <= AddrWidth'(1);
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      gidx_q    <= '0;
      clr_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      clr_cnt_q <= clr_cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      gidx_q    <= gidx_d;
      clr_wr_q  <= clr_wr_d;
    end
  end

  // Busy also covers the cycle where the final clear write sits on the output.
  assign busy_out                   = (state_q == StClear) || clr_wr_q;
  assign write_enable_out           = we_q;
  assign write_register_address_out = addr_q;
  assign write_data_out             = data_q;
  assign grant_index_out            = gidx_q;

endmodule
